// File: rtl/bft_inject_arb.sv
// -----------------------------------------------------------------------------
// bft_inject_arb
// Injection arbiter for a leaf client of the deflection butterfly-fat-tree.
// R local packet sources share one injection port. Sources are picked
// round-robin, and a picked source may keep the port for up to MAX_BURST
// packets. The winning packet is registered as {valid, last, addr, data}
// and is held on out_pkt while the switch asserts net_stall.
//
// Optional feature macro: BFT_ARB_STATS_EN
//   defined     -> per-requester saturating 16-bit accept counters on grant_cnt
//   not defined -> grant_cnt is constant zero and no counter flops are built
// -----------------------------------------------------------------------------
module bft_inject_arb #(
  parameter int R         = 4,
  parameter int N         = 32,
  parameter int D_W       = 32,
  parameter int A_W       = $clog2(N) + 1,
  parameter int MAX_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [R-1:0]           req_v,
  input  logic [R-1:0]           req_last,
  input  logic [R*A_W-1:0]       req_addr,
  input  logic [R*D_W-1:0]       req_data,
  output logic [R-1:0]           req_rdy,
  input  logic                   net_stall,
  output logic [A_W+D_W+1:0]     out_pkt,
  output logic [R*16-1:0]        grant_cnt
);

  localparam int PW    = A_W + D_W + 2;
  localparam int PTR_W = (R > 1) ? $clog2(R) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  // Round-robin helper: (base + off) mod R, with off in 0..R.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] base,
                                               input int                off);
    int sum;
    sum = 32'(base) + off;
    if (sum >= R) begin
      sum = sum - R;
    end else begin
      sum = sum;
    end
    return PTR_W'(sum);
  endfunction

  // Architectural state
  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_owner;
  logic [CNT_W-1:0]   r_cnt;
  logic [PW-1:0]      r_out;

  // Next-state and decode signals
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [PTR_W-1:0]   w_owner_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [PTR_W-1:0]   w_rr_sel;
  logic               w_rr_found;
  logic [PTR_W-1:0]   w_sel;
  logic               w_cand;
  logic               w_slot_free;
  logic               w_accept;
  logic               w_burst_end;
  logic [PW-1:0]      w_load_pkt;

  // Round-robin search: first requesting source starting at r_ptr
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_sel   = r_ptr;
    for (int k = 0; k < R; k++) begin
      if (!w_rr_found && req_v[ptr_add(r_ptr, k)]) begin
        w_rr_found = 1'b1;
        w_rr_sel   = ptr_add(r_ptr, k);
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  // Grant selection, handshake and FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    w_sel       = r_ptr;
    w_cand      = 1'b0;

    // The output slot can take a new packet unless a valid one is stalled.
    w_slot_free = ~r_out[PW-1] | ~net_stall;

    case (r_state)
      ST_IDLE: begin
        w_sel  = w_rr_sel;
        w_cand = w_rr_found;
      end
      ST_LOCK: begin
        // Only the burst owner is eligible; others wait even if it is idle.
        w_sel  = r_owner;
        w_cand = req_v[r_owner];
      end
      default: begin
        w_sel  = r_ptr;
        w_cand = 1'b0;
      end
    endcase

    // Reset forces the handshake closed, since req_rdy is not registered.
    w_accept    = w_cand & w_slot_free & ~rst;
    w_cnt_inc   = r_cnt + CNT_W'(1'b1);
    w_burst_end = req_last[w_sel] | (w_cnt_inc == CNT_W'(MAX_BURST));

    if (w_accept) begin
      if (w_burst_end) begin
        // Burst complete: release the port and move priority past the winner.
        w_state_nxt = ST_IDLE;
        w_ptr_nxt   = ptr_add(w_sel, 1);
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_owner_nxt = r_owner;
      end else begin
        w_state_nxt = ST_LOCK;
        w_owner_nxt = w_sel;
        w_cnt_nxt   = w_cnt_inc;
        w_ptr_nxt   = r_ptr;
      end
    end else begin
      w_state_nxt = r_state;
    end

    req_rdy = {R{w_accept}} & ({{(R-1){1'b0}}, 1'b1} << w_sel);
  end

  // Packet image of the selected requester
  always_comb begin
    w_load_pkt = {1'b1, req_last[w_sel],
                  req_addr[w_sel*A_W +: A_W],
                  req_data[w_sel*D_W +: D_W]};
  end

  // FSM state, priority pointer, burst owner and burst length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= {PTR_W{1'b0}};
      r_owner <= {PTR_W{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output packet register: load on accept, clear when drained, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= {PW{1'b0}};
    end else if (w_accept) begin
      r_out <= w_load_pkt;
    end else if (w_slot_free) begin
      r_out <= {PW{1'b0}};
    end else begin
      r_out <= r_out;
    end
  end

  assign out_pkt = r_out;

`ifdef BFT_ARB_STATS_EN
  for (genvar g = 0; g < R; g++) begin : g_stats
    logic [15:0] r_gcnt;

    // Saturating count of packets accepted from this requester
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_gcnt <= 16'h0000;
      end else if (req_v[g] && req_rdy[g] && (r_gcnt != 16'hFFFF)) begin
        r_gcnt <= r_gcnt + 16'h0001;
      end else begin
        r_gcnt <= r_gcnt;
      end
    end

    assign grant_cnt[g*16 +: 16] = r_gcnt;
  end
`else
  assign grant_cnt = {(R*16){1'b0}};
`endif

endmodule

// File: tb/tb_bft_inject_arb.sv
// -----------------------------------------------------------------------------
// tb_bft_inject_arb
// Scoreboard bench: the driver computes the expected handshake and packet from
// a reference model of the arbitration rules and queues expected packets; a
// separate monitor pops and compares whenever out_pkt presents a new packet.
// Grant counters are expected only when BFT_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_bft_inject_arb;

  localparam int R         = 4;
  localparam int N         = 32;
  localparam int D_W       = 32;
  localparam int A_W       = $clog2(N) + 1;
  localparam int MAX_BURST = 4;
  localparam int PW        = A_W + D_W + 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [R-1:0]       req_v;
  logic [R-1:0]       req_last;
  logic [R*A_W-1:0]   req_addr;
  logic [R*D_W-1:0]   req_data;
  logic [R-1:0]       req_rdy;
  logic               net_stall;
  logic [PW-1:0]      out_pkt;
  logic [R*16-1:0]    grant_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [PW-1:0] pkt;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc    = 0;
  bit   mon_en = 1'b0;

  // Reference model state (plain integers; -1 means no burst owner)
  int m_ptr;
  int m_owner;
  int m_cnt;
  bit m_held;
  int m_gcnt[R];

  always #5 clk = ~clk;

  bft_inject_arb #(
    .R(R), .N(N), .D_W(D_W), .A_W(A_W), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_v     (req_v),
    .req_last  (req_last),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_rdy   (req_rdy),
    .net_stall (net_stall),
    .out_pkt   (out_pkt),
    .grant_cnt (grant_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_owner = -1;
    m_cnt   = 0;
    m_held  = 1'b0;
    for (int i = 0; i < R; i++) m_gcnt[i] = 0;
    sb_q.delete();
  endtask

  function automatic logic [R*16-1:0] exp_gcnt();
    logic [R*16-1:0] b;
    b = '0;
`ifdef BFT_ARB_STATS_EN
    for (int i = 0; i < R; i++) b[i*16 +: 16] = 16'(m_gcnt[i]);
`endif
    return b;
  endfunction

  // One clock cycle of stimulus. Entered just after a rising edge.
  task automatic step(input logic [R-1:0] v, input logic [R-1:0] lst,
                      input logic stall, input bit rnd);
    int           w;
    bit           sf;
    logic [R-1:0] er;
    exp_t         e;
    req_v     = v;
    req_last  = lst;
    net_stall = stall;
    if (rnd) begin
      for (int i = 0; i < R; i++) begin
        req_addr[i*A_W +: A_W] = A_W'($urandom);
        req_data[i*D_W +: D_W] = $urandom;
      end
    end
    // Who should be granted this cycle, from the arbitration rules
    w  = -1;
    sf = !m_held || !stall;
    if (m_owner >= 0) begin
      if (v[m_owner]) w = m_owner;
    end else begin
      for (int k = 0; k < R; k++)
        if (w < 0 && v[(m_ptr + k) % R]) w = (m_ptr + k) % R;
    end
    er = '0;
    if (w >= 0 && sf) er[w] = 1'b1;

    @(negedge clk);
    chk("req_rdy", req_rdy, er);
    chk("grant_cnt", grant_cnt, exp_gcnt());

    if (w >= 0 && sf) begin
      e.pkt = {1'b1, lst[w], req_addr[w*A_W +: A_W], req_data[w*D_W +: D_W]};
      e.cyc = cyc;
      sb_q.push_back(e);
      if (m_gcnt[w] < 65535) m_gcnt[w]++;
      m_cnt++;
      if (lst[w] || m_cnt == MAX_BURST) begin
        m_owner = -1;
        m_ptr   = (w + 1) % R;
        m_cnt   = 0;
      end else begin
        m_owner = w;
      end
      m_held = 1'b1;
    end else if (sf) begin
      m_held = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Monitor: compares each newly presented packet against the scoreboard
  initial begin
    bit            prev_v;
    bit            prev_s;
    logic [PW-1:0] last_exp;
    exp_t          e;
    prev_v   = 1'b0;
    prev_s   = 1'b0;
    last_exp = '0;
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (out_pkt[PW-1]) begin
          if (!prev_v || !prev_s) begin
            if (sb_q.size() == 0) begin
              chk("out_unexpected", out_pkt, '0);
            end else begin
              e = sb_q.pop_front();
              chk("out_pkt", out_pkt, e.pkt);
              chk("out_latency", e.cyc, cyc - 1);
              last_exp = e.pkt;
            end
          end else begin
            chk("out_hold", out_pkt, last_exp);
          end
        end else begin
          chk("out_dropped", (prev_v && prev_s), 1'b0);
          chk("out_missing", (sb_q.size() > 0 && sb_q[0].cyc < cyc), 1'b0);
        end
        prev_v = out_pkt[PW-1];
        prev_s = net_stall;
      end else begin
        prev_v = 1'b0;
        prev_s = 1'b0;
      end
    end
  end

  // Overall time limit
  initial begin
    #3000000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  // Main stimulus sequence
  initial begin
    rst       = 1'b1;
    req_v     = '1;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    net_stall = 1'b0;
    #3;
    chk("reset_out_pkt", out_pkt, '0);
    chk("reset_req_rdy", req_rdy, '0);
    chk("reset_grant_cnt", grant_cnt, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Round-robin with single-packet bursts: grants 0,1,2,3,0
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b1111, 1'b0, 1'b1);

    // Burst lock on requester 1 (never signals last): 4 grants then 2
    for (int i = 0; i < 5; i++) step(4'b1111, 4'b1101, 1'b0, 1'b1);
    step(4'b1000, 4'b1111, 1'b0, 1'b1);
    step(4'b0001, 4'b1111, 1'b0, 1'b1);
    // Requester 1 ends its burst on its 2nd packet
    step(4'b1111, 4'b1101, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b0, 1'b1);

    // Stall hold for 3 cycles with requests pending
    step(4'b1111, 4'b1111, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1111, 4'b1111, 1'b1, 1'b1);
    step(4'b1111, 4'b1111, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);

    // Owner 2 drops req_v mid-burst while requester 0 waits
    step(4'b0100, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0001, 4'b0000, 1'b0, 1'b1);
    step(4'b0101, 4'b0000, 1'b0, 1'b1);
    step(4'b0101, 4'b0100, 1'b0, 1'b1);

    // Single requester 2, addr 5, data A5
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    req_addr[2*A_W +: A_W] = A_W'(5);
    req_data[2*D_W +: D_W] = 32'h0000_00A5;
    step(4'b0100, 4'b0100, 1'b0, 1'b0);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b0, 1'b1);

    // Randomized traffic with occasional stalls
    for (int i = 0; i < 1500; i++)
      step(R'($urandom), R'($urandom), ($urandom_range(0, 3) == 0), 1'b1);

    // Asynchronous reset between edges in the middle of a burst
    step(4'b1111, 4'b0000, 1'b0, 1'b1);
    step(4'b1111, 4'b0000, 1'b0, 1'b1);
    mon_en = 1'b0;
    req_v  = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_pkt", out_pkt, '0);
    chk("midrst_req_rdy", req_rdy, '0);
    chk("midrst_grant_cnt", grant_cnt, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc++;
    model_reset();
    mon_en = 1'b1;
    step(4'b1111, 4'b1111, 1'b0, 1'b1);
    step(4'b1111, 4'b1111, 1'b0, 1'b1);

`ifdef BFT_ARB_STATS_EN
    // Counter saturation: 70000 accepts from requester 0
    for (int i = 0; i < 70000; i++) step(4'b0001, 4'b0001, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("grant_cnt_sat", grant_cnt[15:0], 16'hFFFF);
`endif

    // Drain: every expected packet must have appeared
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    step(4'b0000, 4'b0000, 1'b0, 1'b1);
    chk("scoreboard_drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
